// File: rtl/conv_aux_addr_seq.sv
// Address sequencer for the conv core's bias / noise-weight / noise-pixel memories.
// Tracks accepted output beats of one layer and pulses the noise generator per channel.
module conv_aux_addr_seq #(
    parameter int MAX_CHANNELS = 256,
    parameter int MAX_IMAGE    = 128,
    parameter int LANES        = 4,
    parameter int BIAS_ADDR_W  = 12,
    parameter int NOISE_ADDR_W = 14,
    parameter int CH_W         = $clog2(MAX_CHANNELS) + 1,
    parameter int IMG_W        = $clog2(MAX_IMAGE) + 1
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CH_W-1:0]         cfg_channel_size,
    input  logic [IMG_W-1:0]        cfg_image_size,
    input  logic [BIAS_ADDR_W-1:0]  cfg_bias_base,
    input  logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [BIAS_ADDR_W-1:0]  bias_addr,
    output logic [CH_W-2:0]         noise_w_addr,
    output logic [NOISE_ADDR_W-1:0] noise_addr,
    output logic                    start_noise_gen,
    output logic                    ch_last,
    output logic                    layer_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err_cfg
);

    localparam int SQ_W      = 2 * IMG_W;
    localparam int LANES_LOG = $clog2(LANES);
    localparam int CNT_W     = (SQ_W > NOISE_ADDR_W) ? SQ_W : NOISE_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SQ_W-1:0]         r_beats_per_ch;
    logic [CH_W-1:0]         r_ch_size;
    logic [BIAS_ADDR_W-1:0]  r_bias_base;
    logic [BIAS_ADDR_W-1:0]  r_bias_addr;
    logic [CH_W-2:0]         r_noise_w_addr;
    logic [NOISE_ADDR_W-1:0] r_noise_addr;
    logic                    r_ch_pulse;
    logic                    r_err_cfg;

    logic [SQ_W-1:0] w_img_sq;
    logic            w_img_pow2;
    logic            w_cfg_legal;
    logic            w_beat_acc;
    logic            w_ch_last;
    logic            w_last_ch;
    logic            w_layer_last;

    assign w_img_sq   = SQ_W'(cfg_image_size) * SQ_W'(cfg_image_size);
    assign w_img_pow2 = (cfg_image_size != '0) &&
                        ((cfg_image_size & (cfg_image_size - IMG_W'(1))) == '0);

    assign w_cfg_legal = (cfg_channel_size != '0) &&
                         (cfg_channel_size <= CH_W'(MAX_CHANNELS)) &&
                         w_img_pow2 &&
                         (cfg_image_size <= IMG_W'(MAX_IMAGE)) &&
                         (w_img_sq >= SQ_W'(LANES));

    // Per-channel beat index lives in r_noise_addr; channel index in r_noise_w_addr.
    assign w_beat_acc   = (r_state == S_RUN) && beat_valid && beat_ready;
    assign w_ch_last    = (r_state == S_RUN) &&
                          (CNT_W'(r_noise_addr) == (CNT_W'(r_beats_per_ch) - CNT_W'(1)));
    assign w_last_ch    = ({1'b0, r_noise_w_addr} == (r_ch_size - CH_W'(1)));
    assign w_layer_last = w_ch_last && w_last_ch;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start && w_cfg_legal) w_state_next = S_ARM;
            S_ARM:  w_state_next = S_RUN;
            S_RUN:  if (w_beat_acc && w_layer_last) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_beats_per_ch <= '0;
            r_ch_size      <= '0;
            r_bias_base    <= '0;
            r_bias_addr    <= '0;
            r_noise_w_addr <= '0;
            r_noise_addr   <= '0;
            r_ch_pulse     <= 1'b0;
            r_err_cfg      <= 1'b0;
        end else begin
            r_ch_pulse <= 1'b0;
            if (!abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cfg_legal) begin
                                r_beats_per_ch <= w_img_sq >> LANES_LOG;
                                r_ch_size      <= cfg_channel_size;
                                r_bias_base    <= cfg_bias_base;
                                r_err_cfg      <= 1'b0;
                            end else begin
                                r_err_cfg <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        r_bias_addr    <= r_bias_base;
                        r_noise_w_addr <= '0;
                        r_noise_addr   <= '0;
                    end
                    S_RUN: begin
                        if (w_beat_acc) begin
                            if (!w_ch_last) begin
                                r_noise_addr <= r_noise_addr + NOISE_ADDR_W'(1);
                            end else if (!w_last_ch) begin
                                // Channel boundary: step channel, re-seed the noise generator.
                                r_noise_addr   <= '0;
                                r_noise_w_addr <= r_noise_w_addr + (CH_W-1)'(1);
                                r_bias_addr    <= r_bias_addr + BIAS_ADDR_W'(1);
                                r_ch_pulse     <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bias_addr       = r_bias_addr;
    assign noise_w_addr    = r_noise_w_addr;
    assign noise_addr      = r_noise_addr;
    assign start_noise_gen = (r_state == S_ARM) || r_ch_pulse;
    assign ch_last         = w_ch_last;
    assign layer_last      = w_layer_last;
    assign busy            = (r_state == S_ARM) || (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign err_cfg         = r_err_cfg;

endmodule

// File: tb/tb_conv_aux_addr_seq.sv
// Randomized self-checking bench for conv_aux_addr_seq; expected addresses come
// from the accepted-beat count (channel = k / beats, pixel = k % beats).
module tb_conv_aux_addr_seq;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        abort;
    logic [8:0]  cfg_channel_size;
    logic [7:0]  cfg_image_size;
    logic [11:0] cfg_bias_base;
    logic        beat_valid;
    logic        beat_ready;
    logic [11:0] bias_addr;
    logic [7:0]  noise_w_addr;
    logic [13:0] noise_addr;
    logic        start_noise_gen;
    logic        ch_last;
    logic        layer_last;
    logic        busy;
    logic        done;
    logic        err_cfg;

    int n_checks = 0;
    int n_fail   = 0;

    conv_aux_addr_seq dut (
        .clk              (clk),
        .Reset            (Reset),
        .start            (start),
        .abort            (abort),
        .cfg_channel_size (cfg_channel_size),
        .cfg_image_size   (cfg_image_size),
        .cfg_bias_base    (cfg_bias_base),
        .beat_valid       (beat_valid),
        .beat_ready       (beat_ready),
        .bias_addr        (bias_addr),
        .noise_w_addr     (noise_w_addr),
        .noise_addr       (noise_addr),
        .start_noise_gen  (start_noise_gen),
        .ch_last          (ch_last),
        .layer_last       (layer_last),
        .busy             (busy),
        .done             (done),
        .err_cfg          (err_cfg)
    );

    always #5 clk = ~clk;

    // mode 0: continuous beats, 1: ready toggles every cycle, 2: random valid/ready
    task automatic run_layer(input int ch, input int img, input int base, input int mode);
        int bpc, total, k, cyc, exp_ch, exp_pix, exp_bias;
        bit acc, prev_bnd, tog, exp_cl, exp_ll;
        bpc = img * img / 4;
        total = ch * bpc;
        @(negedge clk);
        cfg_channel_size = 9'(ch);
        cfg_image_size   = 8'(img);
        cfg_bias_base    = 12'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || start_noise_gen !== 1'b1 || done !== 1'b0 || err_cfg !== 1'b0) begin
            n_fail++;
            $display("FAIL arm: busy=%b sng=%b done=%b err=%b, required 1 1 0 0", busy, start_noise_gen, done, err_cfg);
        end
        k = 0; cyc = 0; prev_bnd = 1'b0; tog = 1'b0;
        while (k < total) begin
            @(negedge clk);
            exp_ch   = k / bpc;
            exp_pix  = k % bpc;
            exp_bias = (base + exp_ch) % 4096;
            exp_cl   = (exp_pix == bpc - 1);
            exp_ll   = exp_cl && (exp_ch == ch - 1);
            n_checks++;
            if (noise_addr !== 14'(exp_pix) || noise_w_addr !== 8'(exp_ch) || bias_addr !== 12'(exp_bias)) begin
                n_fail++;
                $display("FAIL run_addr beat %0d: noise=%0d w=%0d bias=%0d, required %0d %0d %0d",
                         k, noise_addr, noise_w_addr, bias_addr, exp_pix, exp_ch, exp_bias);
            end
            n_checks++;
            if (ch_last !== exp_cl || layer_last !== exp_ll || start_noise_gen !== prev_bnd ||
                busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL run_flags beat %0d: cl=%b ll=%b sng=%b busy=%b done=%b, required %b %b %b 1 0",
                         k, ch_last, layer_last, start_noise_gen, busy, done, exp_cl, exp_ll, prev_bnd);
            end
            case (mode)
                0: begin beat_valid = 1'b1; beat_ready = 1'b1; end
                1: begin beat_valid = 1'b1; beat_ready = tog; tog = !tog; end
                default: begin
                    beat_valid = ($urandom % 4) != 0;
                    beat_ready = ($urandom % 3) != 0;
                end
            endcase
            acc = beat_valid && beat_ready;
            prev_bnd = acc && exp_cl && (k < total - 1);
            if (acc) k++;
            cyc++;
            if (cyc > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: accepted %0d beats, required %0d", k, total);
                break;
            end
        end
        @(negedge clk);
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || start_noise_gen !== 1'b0 || ch_last !== 1'b0 || layer_last !== 1'b0) begin
            n_fail++;
            $display("FAIL done_flags: done=%b busy=%b sng=%b cl=%b ll=%b, required 1 0 0 0 0",
                     done, busy, start_noise_gen, ch_last, layer_last);
        end
        n_checks++;
        if (noise_addr !== 14'(bpc - 1) || noise_w_addr !== 8'(ch - 1) || bias_addr !== 12'((base + ch - 1) % 4096)) begin
            n_fail++;
            $display("FAIL done_addr: noise=%0d w=%0d bias=%0d, required %0d %0d %0d",
                     noise_addr, noise_w_addr, bias_addr, bpc - 1, ch - 1, (base + ch - 1) % 4096);
        end
        start = 1'b1;  // must be ignored while in DONE
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || start_noise_gen !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done: done=%b busy=%b sng=%b, required 0 0 0", done, busy, start_noise_gen);
        end
        $display("layer ch=%0d img=%0d base=%0d mode=%0d beats=%0d cycles=%0d", ch, img, base, mode, total, cyc);
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; abort = 1'b0; beat_valid = 1'b0; beat_ready = 1'b0;
        cfg_channel_size = '0; cfg_image_size = '0; cfg_bias_base = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bias_addr, noise_w_addr, noise_addr, start_noise_gen, ch_last, layer_last, busy, done, err_cfg} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: bias=%0d w=%0d noise=%0d flags=%b%b%b%b%b%b, required all 0",
                     bias_addr, noise_w_addr, noise_addr, start_noise_gen, ch_last, layer_last, busy, done, err_cfg);
        end
        Reset = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_basic();
        run_layer(2, 4, 10, 0);
    endtask

    task automatic test_toggle_ready();
        run_layer(1, 8, 0, 1);
    endtask

    task automatic test_illegal();
        int chs [4] = '{1, 0, 257, 1};
        int imgs[4] = '{6, 4, 4, 1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_channel_size = 9'(chs[i]);
            cfg_image_size   = 8'(imgs[i]);
            cfg_bias_base    = 12'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (err_cfg !== 1'b1 || busy !== 1'b0 || start_noise_gen !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_cfg ch=%0d img=%0d: err=%b busy=%b sng=%b, required 1 0 0",
                         chs[i], imgs[i], err_cfg, busy, start_noise_gen);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || err_cfg !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_stay ch=%0d img=%0d: busy=%b err=%b, required 0 1", chs[i], imgs[i], busy, err_cfg);
            end
            $display("illegal config ch=%0d img=%0d", chs[i], imgs[i]);
        end
        run_layer(2, 4, 10, 2);
    endtask

    task automatic test_abort();
        @(negedge clk);
        cfg_channel_size = 9'd256;
        cfg_image_size   = 8'd128;
        cfg_bias_base    = 12'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            beat_valid = 1'b1;
            beat_ready = 1'b1;
            abort = (i == 4);
        end
        @(negedge clk);
        abort = 1'b0;
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || start_noise_gen !== 1'b0 || noise_addr !== 14'd4 || bias_addr !== 12'd100) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b sng=%b noise=%0d bias=%0d, required 0 0 0 4 100",
                     busy, done, start_noise_gen, noise_addr, bias_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
            end
        end
        $display("abort checked");
        run_layer(2, 4, 100, 2);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        cfg_channel_size = 9'd2;
        cfg_image_size   = 8'd4;
        cfg_bias_base    = 12'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            beat_valid = 1'b1;
            beat_ready = 1'b1;
        end
        @(negedge clk);
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        n_checks++;
        if (bias_addr !== 12'd8 || noise_addr !== 14'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: bias=%0d noise=%0d busy=%b, required 8 2 1", bias_addr, noise_addr, busy);
        end
        @(posedge clk);
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if ({bias_addr, noise_w_addr, noise_addr, start_noise_gen, ch_last, layer_last, busy, done, err_cfg} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: bias=%0d w=%0d noise=%0d busy=%b, required all 0",
                     bias_addr, noise_w_addr, noise_addr, busy);
        end
        @(negedge clk);
        Reset = 1'b0;
        $display("async reset checked");
        run_layer(2, 4, 7, 0);
    endtask

    task automatic test_bias_wrap();
        run_layer(3, 2, 4095, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_layer(int'($urandom_range(1, 4)), 2 << $urandom_range(0, 2), int'($urandom_range(0, 4095)), 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_illegal();
        test_abort();
        test_async_reset();
        test_bias_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_aux_addr_seq.md
# conv_aux_addr_seq

Parametrised address sequencer for the convolution core's auxiliary memories (bias BRAM, noise-weight BRAM, noise pixel BRAM). It tracks output-stream beats of one convolution layer, steps the per-channel and per-pixel addresses, and pulses the noise generator at the start of every output channel. It is the next generation of the fixed 256/128/64-channel, 4..128-image, one-pixel-per-count address logic in the conv top level. It adds:
- arbitrary runtime sizes up to parameter limits
- multi-pixel beats
- a layer base offset for the bias address
- configuration error checking
- clean termination with `done`

## Interface
Parameters:
- `MAX_CHANNELS`, 256: largest legal channel count; `CH_W = $clog2(MAX_CHANNELS)+1`.
- `MAX_IMAGE`, 128: largest legal image side; `IMG_W = $clog2(MAX_IMAGE)+1`.
- `LANES`, 4: pixels per output beat (power of 2, ≥1).
- `BIAS_ADDR_W`, 12: bias BRAM address width.
- `NOISE_ADDR_W`, 14: noise pixel address width; must be ≥ `$clog2(MAX_IMAGE*MAX_IMAGE/LANES)`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: layer start; sampled only in IDLE.
- `abort`, in, 1: synchronous abort; returns the block to IDLE with no `done`.
- `cfg_channel_size`, in, `CH_W`: number of output channels.
- `cfg_image_size`, in, `IMG_W`: image side in pixels.
- `cfg_bias_base`, in, `BIAS_ADDR_W`: first bias address of this layer.
- `beat_valid`, in, 1: output stream beat valid (`m_axis_tvalid`).
- `beat_ready`, in, 1: output stream beat ready (`m_axis_tready`).
- `bias_addr`, out, `BIAS_ADDR_W`: current bias BRAM address.
- `noise_w_addr`, out, `CH_W-1`: current noise-weight address, equal to the channel index.
- `noise_addr`, out, `NOISE_ADDR_W`: current noise pixel beat address.
- `start_noise_gen`, out, 1: one-cycle pulse at the start of each channel.
- `ch_last`, out, 1: high while the current beat is the last beat of its channel.
- `layer_last`, out, 1: `ch_last` AND current channel is the last channel.
- `busy`, out, 1: high in ARM and RUN.
- `done`, out, 1: one-cycle pulse when the layer completes.
- `err_cfg`, out, 1: sticky configuration error.

## Operation
- FSM states: IDLE, ARM, RUN, DONE.
- A beat is accepted on a clock edge where `beat_valid & beat_ready` = 1 in RUN. Beats outside RUN are ignored.
- IDLE, `start`=1, config legal:
  - latch the config
  - compute `beats_per_ch = cfg_image_size² / LANES`
  - go to ARM
- Config is legal when all of the following hold:
  - channel size in 1..`MAX_CHANNELS`
  - image size a power of 2 in 1..`MAX_IMAGE`
  - `image_size² ≥ LANES`
- IDLE, `start`=1, config illegal: set `err_cfg`, stay in IDLE. `err_cfg` clears only on the next legal `start` or on `Reset`.
- ARM (one cycle):
  - `bias_addr` ← `cfg_bias_base`; `noise_w_addr` ← 0; `noise_addr` ← 0; beat count ← 0
  - `start_noise_gen`=1
  - go to RUN
- RUN, accepted beat that is not the last of its channel: `noise_addr` +1.
- RUN, accepted beat that is the last of its channel, not the last channel:
  - `noise_addr` ← 0; `noise_w_addr` +1; `bias_addr` +1 (wraps modulo 2^`BIAS_ADDR_W`)
  - `start_noise_gen` pulses on the next cycle
- RUN, accepted beat that is the last beat of the last channel: go to DONE. Addresses hold their values.
- DONE: `done`=1 for one cycle, then IDLE. Addresses keep their final values until the next ARM.
- `abort`=1 in any state: next state IDLE, no `done`, no pulse. Addresses hold their values. `abort` has priority over `start` and over beats.
- `ch_last` and `layer_last` are combinational from the registered counters and are valid in RUN only (0 elsewhere).

## Timing
- After `Reset` all outputs are 0 and the state is IDLE.
- `start` sampled at edge N: ARM during cycle N+1 (`start_noise_gen`=1, `busy`=1); RUN from N+2.
- Counter updates appear the cycle after the accepting edge.
- `start_noise_gen` follows a channel-boundary beat by exactly one cycle. No pulse follows the final beat.
- Final beat accepted at edge M: `done`=1 in cycle M+1, IDLE in M+2, `busy`=0 from M+1.
- Minimum layer length is `channels × beats_per_ch` accepted beats. Stalls (`beat_ready`=0) freeze all counters.
- Back-to-back layers: `start` asserted during DONE is ignored. The earliest accepted restart is on the first IDLE cycle.
- `Reset` asserted mid-RUN clears all state immediately, without waiting for a clock edge.

## Test plan
- 2 channels, image 4, `LANES`=4, base 10, continuous ready: 8 beats. Expect:
  - `noise_addr` 0,1,2,3,0,1,2,3
  - `bias_addr` 10 → 11 after beat 4
  - `start_noise_gen` pulses in ARM and after beat 4
  - `done` one cycle after beat 8
- Image 8, 1 channel, `beat_ready` toggling every cycle: 16 accepted beats. Counters advance only on handshake; `layer_last` is high on beat 16 only.
- Illegal configs, each giving `err_cfg`=1, state IDLE, `busy`=0:
  - image 6
  - channels 0
  - channels 257
  - image 1 with `LANES`=4
- A following legal `start` clears `err_cfg` and runs normally.
- `abort` on beat 5 of a 256-channel, image-128 layer: IDLE next cycle, no `done`; a new `start` restarts from `cfg_bias_base`, `noise_addr` 0.
- `Reset` pulsed mid-RUN, asynchronously between edges: all outputs 0 immediately; `start` after release gives the normal ARM/RUN sequence.
- Base 4095 with 3 channels, `BIAS_ADDR_W`=12: `bias_addr` sequence 4095, 0, 1.
